mag_power_control: RTL and testbench
====================================

MAG_POWER_CONTROL -- requirements
Module: mag_power_control

Interface
REQ-001 Parameter PERIOD, default 10: clocks per power frame; legal range 2..255.
REQ-002 Parameter PWR_W, default 4: width of the power_level input.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port resetn  input  1  asynchronous, active-low reset; one clock domain only.
REQ-005 Port startn  input  1  start/resume request, active-low, level-sensitive.
REQ-006 Port stopn  input  1  pause request, active-low.
REQ-007 Port clearn  input  1  cancel request, active-low.
REQ-008 Port door_closed  input  1  1 = door closed (interlock).
REQ-009 Port timer_done  input  1  1 = cook timer expired.
REQ-010 Port power_level  input  PWR_W  requested on-clocks per frame; sampled only on start from IDLE.
REQ-011 Port mag_on  output  1  magnetron enable.
REQ-012 Port state  output  2  IDLE=00, COOK=01, PAUSE=10, DONE=11.
REQ-013 Port done_pulse  output  1  one-clock pulse on entry to DONE.

Function
REQ-014 All inputs are synchronous to clk; the block adds no synchronisers.
REQ-015 Registers: state, frame_cnt (0..PERIOD-1), duty_q (PWR_W bits), done_pulse.
REQ-016 Transitions are evaluated at each rising edge, in this priority order per state:
REQ-017 IDLE: clearn=0 -> IDLE; startn=0 & door_closed=1 & timer_done=0 & power_level!=0 -> COOK, duty_q<=power_level, frame_cnt<=0; otherwise hold.
REQ-018 COOK: clearn=0 -> IDLE; timer_done=1 -> DONE; door_closed=0 or stopn=0 -> PAUSE; otherwise hold.
REQ-019 PAUSE: clearn=0 -> IDLE; timer_done=1 -> DONE; startn=0 & door_closed=1 -> COOK (duty_q and frame_cnt retained); otherwise hold.
REQ-020 DONE: clearn=0 or door_closed=0 -> IDLE; otherwise hold; startn is ignored.
REQ-021 Simultaneous startn=0 and stopn=0 in PAUSE resumes to COOK; simultaneous startn=0 and clearn=0 anywhere goes to IDLE.
REQ-022 frame_cnt increments each clock in COOK, wraps PERIOD-1 -> 0, holds in PAUSE, and is forced to 0 in IDLE and DONE.
REQ-023 mag_on = (state==COOK) & (frame_cnt < duty_q) & door_closed; the only combinational input path is door_closed, so door opening drops mag_on in the same cycle.
REQ-024 duty_q >= PERIOD gives continuous mag_on while in COOK.
REQ-025 duty_q = 1..PERIOD-1 gives exactly duty_q on-clocks followed by PERIOD-duty_q off-clocks per frame, aligned to frame_cnt=0.
REQ-026 Latency: mag_on rises in the first cycle state==COOK, i.e. one clock after the edge that sampled the start condition.
REQ-027 done_pulse is high for exactly the one cycle following a transition into DONE; it is never high for two consecutive cycles.
REQ-028 power_level changes while in COOK or PAUSE have no effect until the next start from IDLE.

Reset
REQ-029 resetn=0 asynchronously forces state=IDLE, frame_cnt=0, duty_q=0, done_pulse=0, and therefore mag_on=0, regardless of clk.
REQ-030 Reset asserted mid-COOK drops mag_on immediately; after release the block waits in IDLE for a fresh start.
REQ-031 The first clock edge after resetn deasserts evaluates transitions normally.

Verification
REQ-032 PERIOD=10, power_level=3, door_closed=1, startn pulsed 1 clock -> state=01; mag_on pattern 1,1,1 then 0 x7, repeating every 10 clocks.
REQ-033 COOK with frame_cnt=5, door_closed=0 -> mag_on=0 in the same cycle, state=10 next clock; door closed and startn=0 -> COOK resumes at frame_cnt=5.
REQ-034 COOK, timer_done=1 for 1 clock -> state=11 and done_pulse=1 for exactly 1 clock, mag_on=0; clearn=0 -> state=00.
REQ-035 IDLE with power_level=0, or door_closed=0, plus startn=0 -> stays 00 and mag_on=0; power_level=15 with PERIOD=10 -> mag_on continuously 1 in COOK.
REQ-036 COOK at power_level=6, resetn pulsed low between clock edges -> mag_on=0 and state=00 before the next edge; no activity until a new start.
REQ-037 PAUSE with startn=0, stopn=0 and clearn=0 asserted together -> state=00.

Source files
------------

// File: rtl/mag_power_control.sv
// Microwave magnetron power controller: cook/pause/done sequencing with a
// frame-based duty-cycle modulator driving the magnetron enable.
module mag_power_control #(
  parameter int PERIOD = 10,
  parameter int PWR_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [PWR_W-1:0] power_level,
  output logic             mag_on,
  output logic [1:0]       state,
  output logic             done_pulse
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COOK  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam int CNT_W = 8;
  localparam int CMP_W = (PWR_W > CNT_W) ? PWR_W : CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [PWR_W-1:0]   duty_q, duty_d;
  logic               done_pulse_q, done_pulse_d;

  logic [CMP_W-1:0]   cnt_ext, duty_ext;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    duty_d      = duty_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (!clearn) begin
          state_d = S_IDLE;
        end else if (!startn && door_closed && !timer_done && (power_level != '0)) begin
          state_d = S_COOK;
          duty_d  = power_level;
        end
      end
      S_COOK: begin
        if (!clearn)                    state_d = S_IDLE;
        else if (timer_done)            state_d = S_DONE;
        else if (!door_closed || !stopn) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (!clearn)                      state_d = S_IDLE;
        else if (timer_done)              state_d = S_DONE;
        else if (!startn && door_closed)  state_d = S_COOK;
      end
      S_DONE: begin
        if (!clearn || !door_closed) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The counter only advances on edges that stay in COOK, so a pause taken
    // at count N resumes at count N.
    unique case (state_d)
      S_IDLE, S_DONE: frame_cnt_d = '0;
      S_PAUSE:        frame_cnt_d = frame_cnt_q;
      S_COOK: begin
        if (state_q == S_COOK)
          frame_cnt_d = (frame_cnt_q == LAST_CNT) ? '0 : frame_cnt_q + 1'b1;
        else if (state_q == S_IDLE)
          frame_cnt_d = '0;
      end
      default: frame_cnt_d = '0;
    endcase

    done_pulse_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= '0;
      duty_q       <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      duty_q       <= duty_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign cnt_ext  = CMP_W'(frame_cnt_q);
  assign duty_ext = CMP_W'(duty_q);

  // door_closed is the only combinational path so an opening door cuts power
  // in the same cycle.
  assign mag_on     = (state_q == S_COOK) && (cnt_ext < duty_ext) && door_closed;
  assign state      = state_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_mag_power_control.sv
// Directed self-checking bench for mag_power_control (PERIOD=10, PWR_W=4).
module tb_mag_power_control;

  logic       clk = 1'b0;
  logic       resetn;
  logic       startn, stopn, clearn, door_closed, timer_done;
  logic [3:0] power_level;
  logic       mag_on;
  logic [1:0] state;
  logic       done_pulse;

  int vectors = 0;
  int miscompares = 0;

  mag_power_control #(.PERIOD(10), .PWR_W(4)) dut (
    .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed), .timer_done(timer_done),
    .power_level(power_level), .mag_on(mag_on), .state(state),
    .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [1:0] want);
    vectors++;
    if (state !== want) begin
      miscompares++;
      $display("FAIL %s state: got %b want %b", name, state, want);
    end
  endtask

  task automatic expect_mag(input string name, input logic want);
    vectors++;
    if (mag_on !== want) begin
      miscompares++;
      $display("FAIL %s mag_on: got %b want %b", name, mag_on, want);
    end
  endtask

  task automatic expect_done(input string name, input logic want);
    vectors++;
    if (done_pulse !== want) begin
      miscompares++;
      $display("FAIL %s done_pulse: got %b want %b", name, done_pulse, want);
    end
  endtask

  task automatic idle_inputs();
    startn = 1; stopn = 1; clearn = 1; door_closed = 1; timer_done = 0;
    power_level = 4'd0;
  endtask

  task automatic start_cook(input logic [3:0] pwr);
    power_level = pwr; startn = 0;
    tick();
    startn = 1;
  endtask

  task automatic clear_to_idle();
    clearn = 0;
    tick();
    clearn = 1;
    expect_state("clear", 2'b00);
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    #12;
    expect_state("reset", 2'b00);
    expect_mag("reset", 1'b0);
    expect_done("reset", 1'b0);
    resetn = 1;
    tick();
    expect_state("post_reset", 2'b00);
  endtask

  task automatic test_duty_pattern();
    start_cook(4'd3);
    power_level = 4'd9;  // ignored until the next start from IDLE
    for (int i = 0; i < 20; i++) begin
      expect_state("duty3", 2'b01);
      expect_mag($sformatf("duty3_cyc%0d", i), (i % 10) < 3);
      tick();
    end
    clear_to_idle();
    expect_mag("duty3_cleared", 1'b0);
  endtask

  task automatic test_pause_resume();
    start_cook(4'd7);
    repeat (5) tick();                 // frame_cnt = 5
    expect_mag("pre_door_open", 1'b1);
    door_closed = 0;
    #1;
    expect_mag("door_open_same_cycle", 1'b0);
    expect_state("door_open_same_cycle", 2'b01);
    tick();
    expect_state("door_open_pause", 2'b10);
    tick();
    expect_state("pause_hold", 2'b10);
    door_closed = 1; startn = 0;
    #1;
    expect_mag("pause_door_closed", 1'b0);
    tick();
    startn = 1;
    expect_state("resume", 2'b01);
    expect_mag("resume_cnt5", 1'b1);
    tick();
    expect_mag("resume_cnt6", 1'b1);
    tick();
    expect_mag("resume_cnt7", 1'b0);   // would be 1 had the count restarted
    stopn = 0;
    tick();
    stopn = 1;
    expect_state("stopn_pause", 2'b10);
  endtask

  task automatic test_done();
    startn = 0; stopn = 0;             // start wins over stop in PAUSE
    tick();
    startn = 1; stopn = 1;
    expect_state("start_stop_resume", 2'b01);
    timer_done = 1;
    tick();
    timer_done = 0;
    expect_state("timer_done", 2'b11);
    expect_done("timer_done", 1'b1);
    expect_mag("timer_done", 1'b0);
    tick();
    expect_done("done_second_cycle", 1'b0);
    expect_state("done_hold", 2'b11);
    startn = 0;
    tick();
    startn = 1;
    expect_state("done_ignores_start", 2'b11);
    expect_done("done_ignores_start", 1'b0);
    clear_to_idle();
  endtask

  task automatic test_no_start();
    power_level = 4'd0; startn = 0;
    tick();
    expect_state("zero_power", 2'b00);
    expect_mag("zero_power", 1'b0);
    power_level = 4'd5; door_closed = 0;
    tick();
    expect_state("door_open_start", 2'b00);
    expect_mag("door_open_start", 1'b0);
    door_closed = 1; timer_done = 1;
    tick();
    timer_done = 0; startn = 1;
    expect_state("timer_done_start", 2'b00);
    start_cook(4'd15);
    for (int i = 0; i < 12; i++) begin
      expect_mag($sformatf("duty15_cyc%0d", i), 1'b1);
      tick();
    end
    clear_to_idle();
  endtask

  task automatic test_async_reset();
    start_cook(4'd6);
    tick();
    expect_mag("pre_reset_cook", 1'b1);
    #2 resetn = 0;
    #1;
    expect_state("async_reset", 2'b00);
    expect_mag("async_reset", 1'b0);
    #1 resetn = 1;
    repeat (3) tick();
    expect_state("after_reset_wait", 2'b00);
    expect_mag("after_reset_wait", 1'b0);
    start_cook(4'd2);
    expect_state("fresh_start", 2'b01);
    expect_mag("fresh_start", 1'b1);
    tick(); tick();
    expect_mag("fresh_start_cnt2", 1'b0);
    clear_to_idle();
  endtask

  task automatic test_pause_clear();
    start_cook(4'd4);
    stopn = 0;
    tick();
    expect_state("pause_for_clear", 2'b10);
    startn = 0; clearn = 0;
    tick();
    startn = 1; stopn = 1; clearn = 1;
    expect_state("pause_all_asserted", 2'b00);
    power_level = 4'd5; startn = 0; clearn = 0;
    tick();
    startn = 1; clearn = 1;
    expect_state("idle_start_clear", 2'b00);
  endtask

  task automatic test_pause_done_door();
    start_cook(4'd4);
    stopn = 0;
    tick();
    stopn = 1;
    timer_done = 1;
    tick();
    timer_done = 0;
    expect_state("pause_timer_done", 2'b11);
    expect_done("pause_timer_done", 1'b1);
    door_closed = 0;
    tick();
    door_closed = 1;
    expect_state("done_door_open", 2'b00);
  endtask

  initial begin
    test_reset();
    test_duty_pattern();
    test_pause_resume();
    test_done();
    test_no_start();
    test_async_reset();
    test_pause_clear();
    test_pause_done_door();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
